// File: rtl/seven_seg_scanner.sv
// Multiplexing driver for common-anode 7-segment displays: prescaled digit slots, dead time,
// PWM brightness and per-digit masking. Optional macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.

module seven_seg_decoder (
    input  logic [3:0] hex_i,
    output logic [6:0] segments_o
);
    // Active-low codes, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        case (hex_i)
            4'h0:    segments_o = 7'h40;
            4'h1:    segments_o = 7'h79;
            4'h2:    segments_o = 7'h24;
            4'h3:    segments_o = 7'h30;
            4'h4:    segments_o = 7'h19;
            4'h5:    segments_o = 7'h12;
            4'h6:    segments_o = 7'h02;
            4'h7:    segments_o = 7'h78;
            4'h8:    segments_o = 7'h00;
            4'h9:    segments_o = 7'h10;
            4'hA:    segments_o = 7'h08;
            4'hB:    segments_o = 7'h03;
            4'hC:    segments_o = 7'h46;
            4'hD:    segments_o = 7'h21;
            4'hE:    segments_o = 7'h06;
            default: segments_o = 7'h0E;
        endcase
    end
endmodule

module seven_seg_scanner #(
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE_LOG2 = 10,
    parameter int BLANK_CYCLES  = 16,
    parameter int BRIGHT_W      = 4
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic [NUM_DIGITS*5-1:0]                               digits,
    input  logic [NUM_DIGITS-1:0]                                 digit_en,
    input  logic [BRIGHT_W-1:0]                                   brightness,
    output logic [6:0]                                            segments,
    output logic                                                  point,
    output logic [NUM_DIGITS-1:0]                                 anodes,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] scan_idx,
    output logic                                                  frame_tick
);
    localparam int                       IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESCALE_LOG2-1:0] BLANK_CNT = PRESCALE_LOG2'(BLANK_CYCLES);

    logic [PRESCALE_LOG2-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]         scan_idx_q, scan_idx_d;

    // Per-slot capture of the digit being shown.
    logic [3:0]               hex_q;
    logic                     point_n_q;
    logic                     blank_q;
    logic                     en_q;
    logic [BRIGHT_W-1:0]      bright_q;

    logic [6:0]               segments_q;
    logic                     point_q;
    logic [NUM_DIGITS-1:0]    anodes_q;
    logic                     frame_tick_q;

    logic                     slot_start;
    logic                     slot_end;
    logic                     lit;
    logic                     blank_d;
    logic [4:0]               cur_digit;
    logic [6:0]               dec_seg;

    seven_seg_decoder u_decoder (
        .hex_i      (hex_q),
        .segments_o (dec_seg)
    );

    always_comb begin
        // NOTE: every combinational output gets a value before any branch, so no latch is inferred.
        slot_start = (slot_cnt_q == '0);
        slot_end   = (slot_cnt_q == '1);
        slot_cnt_d = slot_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (slot_end) begin
            scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + 1'b1;
        end
        cur_digit = digits[5*int'(scan_idx_q) +: 5];
        lit = (slot_cnt_q >= BLANK_CNT) && en_q
              && (slot_cnt_q[PRESCALE_LOG2-1 -: BRIGHT_W] < bright_q);
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Frame snapshot keeps the blanking decision consistent across all slots of one frame.
    logic [NUM_DIGITS*5-1:0] frame_digits_q;
    logic [NUM_DIGITS-1:0]   zero_run;

    always_comb begin
        zero_run = '0;
        zero_run[NUM_DIGITS-1] = (frame_digits_q[5*(NUM_DIGITS-1) +: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_run[i] = zero_run[i+1] && (frame_digits_q[5*i +: 4] == 4'h0);
        end
        blank_d = (scan_idx_q != '0) && zero_run[scan_idx_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_digits_q <= '0;
        end else if (slot_start && (scan_idx_q == '0)) begin
            frame_digits_q <= digits;
        end
    end
`else
    assign blank_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q   <= '0;
            scan_idx_q   <= '0;
            hex_q        <= 4'h0;
            point_n_q    <= 1'b1;
            blank_q      <= 1'b1;
            en_q         <= 1'b0;
            bright_q     <= '0;
            segments_q   <= 7'h7F;
            point_q      <= 1'b1;
            anodes_q     <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            scan_idx_q <= scan_idx_d;
            if (slot_start) begin
                hex_q     <= cur_digit[3:0];
                point_n_q <= cur_digit[4];
                blank_q   <= blank_d;
                en_q      <= digit_en[scan_idx_q];
                bright_q  <= brightness;
            end
            // Segments settle one cycle after capture, ahead of the first lit cycle.
            segments_q   <= blank_q ? 7'h7F : dec_seg;
            point_q      <= point_n_q;
            anodes_q     <= lit ? ~(NUM_DIGITS'(1) << scan_idx_q) : '1;
            frame_tick_q <= slot_end && (scan_idx_q == LAST_IDX);
        end
    end

    assign segments   = segments_q;
    assign point      = point_q;
    assign anodes     = anodes_q;
    assign scan_idx   = scan_idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed scoreboard bench for seven_seg_scanner (4 digits, 16-cycle slots, 2 dead cycles, 2-bit brightness).

module tb_seven_seg_scanner;

    logic        clk;
    logic        reset;
    logic [19:0] digits;
    logic [3:0]  digit_en;
    logic [1:0]  brightness;
    logic [6:0]  segments;
    logic        point;
    logic [3:0]  anodes;
    logic [1:0]  scan_idx;
    logic        frame_tick;

    seven_seg_scanner #(
        .NUM_DIGITS    (4),
        .PRESCALE_LOG2 (4),
        .BLANK_CYCLES  (2),
        .BRIGHT_W      (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .digit_en   (digit_en),
        .brightness (brightness),
        .segments   (segments),
        .point      (point),
        .anodes     (anodes),
        .scan_idx   (scan_idx),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic       ft;
        logic [1:0] idx;
        logic       seg_chk;
        logic [6:0] seg;
        logic       pt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pcyc   = 0;  // output cycle index of the last planned expectation
    int   rcyc   = 0;  // output cycle index of the last compared state

    // Settings the display is expected to show this frame.
    logic [4:0] m_dig [4];
    logic [3:0] m_en;
    int         m_bright;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic bit blanked(input int slot);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (slot == 0) return 1'b0;
        for (int j = slot; j < 4; j++) begin
            if (m_dig[j][3:0] != 4'h0) return 1'b0;
        end
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_digits(input logic [19:0] d);
        digits = d;
        for (int i = 0; i < 4; i++) m_dig[i] = d[5*i +: 5];
    endtask

    // Expected outputs, referenced to the registered outputs: anode low for slot counts 3..4*brightness.
    task automatic plan(input int n);
        for (int j = 0; j < n; j++) begin
            exp_t e;
            int   cnt;
            int   slot;
            pcyc++;
            cnt       = pcyc % 16;
            slot      = (pcyc / 16) % 4;
            e.idx     = 2'(slot);
            e.ft      = (pcyc % 64 == 0);
            e.an      = 4'hF;
            if (m_en[slot] && cnt >= 3 && cnt <= 4 * m_bright) e.an[slot] = 1'b0;
            e.seg_chk = (cnt >= 2);
            e.seg     = blanked(slot) ? 7'h7F : dec(m_dig[slot][3:0]);
            e.pt      = m_dig[slot][4];
            sb.push_back(e);
        end
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) begin
            exp_t e;
            @(posedge clk);
            @(negedge clk);
            rcyc++;
            if (sb.size() == 0) begin
                $display("FAIL scoreboard_underflow: observed 0 entries expected at least 1 at cycle %0d", rcyc);
                $fatal(1, "scoreboard empty");
            end
            e = sb.pop_front();
            check($sformatf("anodes@%0d", rcyc), 32'(anodes), 32'(e.an));
            check($sformatf("frame_tick@%0d", rcyc), 32'(frame_tick), 32'(e.ft));
            check($sformatf("scan_idx@%0d", rcyc), 32'(scan_idx), 32'(e.idx));
            if (e.seg_chk) begin
                check($sformatf("segments@%0d", rcyc), 32'(segments), 32'(e.seg));
                check($sformatf("point@%0d", rcyc), 32'(point), 32'(e.pt));
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_anodes"}, 32'(anodes), 32'hF);
        check({tag, "_segments"}, 32'(segments), 32'h7F);
        check({tag, "_point"}, 32'(point), 32'h1);
        check({tag, "_scan_idx"}, 32'(scan_idx), 32'h0);
        check({tag, "_frame_tick"}, 32'(frame_tick), 32'h0);
    endtask

    initial begin
        reset      = 1'b1;
        digit_en   = 4'hF;
        brightness = 2'd3;
        set_digits({5'h13, 5'h02, 5'h11, 5'h0F});
        m_en       = 4'hF;
        m_bright   = 3;

        // Reset held, then released so the next edge starts slot 0 at count 0.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset_hold");
        reset = 1'b0;
        pcyc  = 0;
        rcyc  = 0;

        // Full brightness, all digits: two frames.
        plan(128);
        run(128);

        // Brightness 1: two lit cycles per slot.
        brightness = 2'd1;
        m_bright   = 1;
        plan(64);
        run(64);

        // Brightness 0: dark frame, frame_tick period unchanged.
        brightness = 2'd0;
        m_bright   = 0;
        plan(64);
        run(64);

        // Digit 2 masked, full brightness.
        brightness = 2'd3;
        m_bright   = 3;
        digit_en   = 4'b1011;
        m_en       = 4'b1011;
        plan(64);
        run(64);

        // Mid-slot change of digit 0 is ignored until the next frame.
        digit_en = 4'hF;
        m_en     = 4'hF;
        set_digits({5'h13, 5'h02, 5'h11, 5'h05});
        plan(5);
        run(5);
        digits[4:0] = 5'h07;
        plan(59);
        run(59);
        m_dig[0] = 5'h07;
        plan(64);
        run(64);

        // One-cycle reset at count 9 of slot 2.
        plan(41);
        run(41);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("reset_mid");
        reset = 1'b0;
        pcyc  = 0;
        rcyc  = 0;
        plan(64);
        run(64);

        // Leading-zero patterns: hex d3..d0 = 0,4,0,0 then all zero.
        set_digits({5'h10, 5'h14, 5'h10, 5'h10});
        plan(64);
        run(64);
        set_digits({5'h10, 5'h10, 5'h10, 5'h10});
        plan(64);
        run(64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
